// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master -- simplified single-wire serial master.
//
// Sends a start bit, the target address (MSB first) and a read/write bit.
// It then releases the line and waits up to ACK_TMO cycles for an
// acknowledge. On acknowledge it either writes a data word (MSB first) or
// reads one back. It finishes with a stop bit and a one-cycle done pulse.
//
// Parameters
//   ADDR_W   width of the target address field
//   DATA_W   width of the data field
//   ACK_TMO  maximum number of clk cycles spent waiting for an acknowledge
//
// Ports
//   clk      single clock, all state changes on its rising edge
//   reset    asynchronous active-high reset
//   start    transaction request, only sampled while idle
//   addr     target address, latched on accept
//   rw       1 = read, 0 = write, latched on accept
//   wr_data  write payload, latched on accept
//   sda_in   line from target: acknowledge, then read data
//   sda      line to target
//   sda_oe   1 = master drives sda, 0 = line released
//   busy     high from accept through the done cycle
//   done     one-cycle completion pulse
//   nack     valid with done, 1 = no acknowledge within ACK_TMO cycles
//   rd_data  read result, valid from done until the next accept
// ---------------------------------------------------------------------------
module i2c_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int ACK_TMO = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sda_in,
  output logic              sda,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_RW, S_ACK, S_WDATA, S_RDATA, S_STOP, S_DONE
  } state_t;

  localparam int BIT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int BIT_W   = $clog2(BIT_MAX + 1);
  localparam int TMO_W   = $clog2(ACK_TMO + 1);

  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;    // bit index within ADDR/WDATA/RDATA
  logic [TMO_W-1:0]  tmo_q, tmo_d;    // cycles already spent in ACK
  logic              ack_q, ack_d;    // acknowledge seen, leave ACK next edge
  logic [ADDR_W-1:0] addr_q;          // shifts left, MSB is the bit on the line
  logic [DATA_W-1:0] wdat_q;          // shifts left, MSB is the bit on the line
  logic              rw_q;
  logic [DATA_W-1:0] rsh_q;           // partial read word, hidden until complete
  logic [DATA_W-1:0] rsh_next;
  logic [DATA_W:0]   rsh_ext;
  logic              accept;
  logic              ack_timeout;

  assign accept      = (state_q == S_IDLE) && start;
  // Only reached if no acknowledge has been seen on any earlier ACK cycle.
  assign ack_timeout = (state_q == S_ACK) && !ack_q && !sda_in && (tmo_q == TMO_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    tmo_d    = tmo_q;
    ack_d    = ack_q;
    sda      = 1'b1;
    sda_oe   = 1'b1;
    busy     = 1'b1;
    done     = 1'b0;
    rsh_ext  = {rsh_q, sda_in};
    rsh_next = rsh_ext[DATA_W-1:0];

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_START;
      end
      S_START: begin
        sda     = 1'b0;
        bit_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        sda = addr_q[ADDR_W-1];
        if (bit_q == ADDR_LAST) begin
          bit_d   = '0;
          state_d = S_RW;
        end else begin
          bit_d = bit_q + BIT_ONE;
        end
      end
      S_RW: begin
        sda     = rw_q;
        tmo_d   = '0;
        ack_d   = 1'b0;
        state_d = S_ACK;
      end
      S_ACK: begin
        // The acknowledge is registered first and acted on one edge later.
        sda_oe = 1'b0;
        if (ack_q) begin
          bit_d   = '0;
          state_d = rw_q ? S_RDATA : S_WDATA;
        end else if (sda_in) begin
          ack_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_STOP;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_WDATA: begin
        sda = wdat_q[DATA_W-1];
        if (bit_q == DATA_LAST) state_d = S_STOP;
        else                    bit_d   = bit_q + BIT_ONE;
      end
      S_RDATA: begin
        sda_oe = 1'b0;
        if (bit_q == DATA_LAST) state_d = S_STOP;
        else                    bit_d   = bit_q + BIT_ONE;
      end
      S_STOP: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdat_q  <= '0;
      rw_q    <= 1'b0;
      rsh_q   <= '0;
      rd_data <= '0;
      nack    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        wdat_q <= wr_data;
        rw_q   <= rw;
        nack   <= 1'b0;
      end
      if (state_q == S_ADDR)  addr_q <= addr_q << 1;
      if (state_q == S_WDATA) wdat_q <= wdat_q << 1;
      if (state_q == S_RDATA) begin
        rsh_q <= rsh_next;
        if (bit_q == DATA_LAST) rd_data <= rsh_next;
      end
      if (ack_timeout) nack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_master -- self-checking bench for i2c_master.
// A transaction-level model builds the expected per-cycle line activity
// (drive/release, bit value, busy, done) from the address, direction,
// payload and acknowledge delay. Each cycle of the DUT is then compared
// against that model.
// ---------------------------------------------------------------------------
module tb_i2c_master;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int ACK_TMO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] wr_data;
  logic              sda_in;
  logic              sda;
  logic              sda_oe;
  logic              busy;
  logic              done;
  logic              nack;
  logic [DATA_W-1:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_rd;   // model of the rd_data register

  i2c_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .rw(rw),
    .wr_data(wr_data), .sda_in(sda_in), .sda(sda), .sda_oe(sda_oe),
    .busy(busy), .done(done), .nack(nack), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Runs one transaction and checks every cycle from START to DONE, plus the
  // idle cycle(s) after it. d = ACK cycle on which the target first pulls
  // sda_in high (d >= ACK_TMO means it never acknowledges).
  task automatic run_txn(input string name, input logic [ADDR_W-1:0] a,
                         input logic r, input logic [DATA_W-1:0] w,
                         input logic [DATA_W-1:0] rdat, input int d,
                         input bit pre_accepted, input bit hold,
                         input int pulse_at);
    logic e_oe [64];
    logic e_sda[64];
    logic drv  [64];
    int   n, stop_k, n_ack;
    bit   acked;
    logic [3:0] obs, exp;
    logic [DATA_W-1:0] exp_cur;

    for (int i = 0; i < 64; i++) begin
      e_oe[i] = 1'b1; e_sda[i] = 1'b1; drv[i] = 1'b0;
    end
    acked = (d < ACK_TMO);
    n = 1;
    e_sda[n] = 1'b0; n++;                                 // start bit
    for (int i = ADDR_W - 1; i >= 0; i--) begin e_sda[n] = a[i]; n++; end
    e_sda[n] = r; n++;                                    // direction bit
    n_ack = acked ? d + 2 : ACK_TMO;
    for (int j = 0; j < n_ack; j++) begin
      e_oe[n] = 1'b0; drv[n] = (j >= d); n++;
    end
    if (acked) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (r) begin e_oe[n] = 1'b0; drv[n] = rdat[i]; end
        else   e_sda[n] = w[i];
        n++;
      end
    end
    stop_k = n; n++;                                      // stop bit
    // n is now the done cycle (STOP and DONE both drive sda=1)

    if (!pre_accepted) begin
      @(negedge clk);
      addr = a; rw = r; wr_data = w; start = 1'b1; sda_in = 1'b0;
      @(posedge clk); #1;
    end

    for (int k = 1; k <= n; k++) begin
      sda_in = drv[k];
      start  = hold || (k == pulse_at);
      @(negedge clk);
      obs = {sda_oe, (sda_oe ? sda : 1'b0), busy, done};
      exp = {e_oe[k], (e_oe[k] ? e_sda[k] : 1'b0), 1'b1, (k == n)};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d {oe,sda,busy,done}: got %b expected %b", name, k, obs, exp);
      end
      exp_cur = (r && acked && k >= stop_k) ? rdat : exp_rd;
      n_tests++;
      if (rd_data !== exp_cur) begin
        n_fail++;
        $display("FAIL %s cycle %0d rd_data: got %b expected %b", name, k, rd_data, exp_cur);
      end
      if (k == n) begin
        n_tests++;
        if (nack !== !acked) begin
          n_fail++;
          $display("FAIL %s nack at done: got %b expected %b", name, nack, !acked);
        end
      end
      @(posedge clk); #1;
    end
    if (r && acked) exp_rd = rdat;

    // first cycle after DONE must be idle
    sda_in = 1'b0;
    start  = hold;
    @(negedge clk);
    n_tests++;
    if ({busy, done, sda_oe, sda} !== 4'b0011) begin
      n_fail++;
      $display("FAIL %s idle after done {busy,done,oe,sda}: got %b expected 0011", name, {busy, done, sda_oe, sda});
    end
    @(posedge clk); #1;
    if (hold) begin
      start = 1'b0;                 // that edge accepted the next transaction
    end else begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s still idle (start not queued): got busy=%b expected 0", name, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wr_data = '0; sda_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({sda, sda_oe, busy, done, nack, rd_data} !== {5'b11000, {DATA_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_values {sda,oe,busy,done,nack,rd}: got %b expected %b",
               {sda, sda_oe, busy, done, nack, rd_data}, {5'b11000, {DATA_W{1'b0}}});
    end
    reset = 1'b0;
    exp_rd = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_txn("write", 4'b1100, 1'b0, 4'b1010, 4'b0000, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_read();
    run_txn("read", 4'b1100, 1'b1, 4'b0000, 4'b0110, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_nack();
    run_txn("nack", 4'b1100, 1'b1, 4'b0000, 4'b1001, ACK_TMO, 1'b0, 1'b0, 0);
  endtask

  task automatic test_delayed_ack();
    run_txn("delayed_ack", 4'b1100, 1'b0, 4'b1010, 4'b0000, 2, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    @(negedge clk);
    addr = 4'b1100; rw = 1'b0; wr_data = 4'b1010; start = 1'b1; sda_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);      // now in cycle 11: third WDATA bit
    @(negedge clk);
    n_tests++;
    if ({sda_oe, sda, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_mid wdata bit2 {oe,sda,busy}: got %b expected 111", {sda_oe, sda, busy});
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({sda, sda_oe, busy, done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_mid async {sda,oe,busy,done}: got %b expected 1100", {sda, sda_oe, busy, done});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({sda, sda_oe, busy, done, rd_data} !== {4'b1100, {DATA_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_mid next cycle {sda,oe,busy,done,rd}: got %b expected 1100_0000",
               {sda, sda_oe, busy, done, rd_data});
    end
    exp_rd = '0;
    reset  = 1'b0;
    sda_in = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL reset_mid no done after reset: got activity expected none");
    end
  endtask

  task automatic test_back_to_back();
    // start pulsed mid-transaction must be ignored
    run_txn("busy_pulse", 4'b0101, 1'b0, 4'b0011, 4'b0000, 0, 1'b0, 1'b0, 5);
    // start held through DONE restarts on the first idle cycle
    run_txn("hold_first", 4'b1001, 1'b0, 4'b0110, 4'b0000, 1, 1'b0, 1'b1, 0);
    run_txn("hold_second", 4'b1001, 1'b0, 4'b0110, 4'b0000, 1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w, rd;
    logic r;
    int d;
    for (int t = 0; t < 8; t++) begin
      a  = ADDR_W'($urandom);
      w  = DATA_W'($urandom);
      rd = DATA_W'($urandom);
      r  = 1'($urandom);
      d  = $urandom_range(0, ACK_TMO);
      run_txn($sformatf("random%0d", t), a, r, w, rd, d, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_delayed_ack();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
